// File: rtl/ram_resp_pkg.sv
// ram_resp_pkg: shared constants and types for the RAM responder
//   IO_* : byte offsets inside the I/O window
//   ST_* : bit positions inside the status byte
//   region_t : address decode result
package ram_resp_pkg;
    localparam logic [3:0] IO_TX   = 4'h0;
    localparam logic [3:0] IO_STAT = 4'h4;
    localparam logic [3:0] IO_CNT0 = 4'h8;
    localparam logic [3:0] IO_CNT1 = 4'h9;
    localparam logic [3:0] IO_CNT2 = 4'hA;
    localparam logic [3:0] IO_CNT3 = 4'hB;
    localparam logic [3:0] IO_LAST = IO_CNT3;
    localparam int ST_EMPTY = 0;
    localparam int ST_FULL  = 1;
    localparam int ST_OVF   = 2;
    typedef enum logic [1:0] {REG_RAM, REG_IO, REG_NONE} region_t;
endpackage

// File: rtl/ram_resp_fifo.sv
// ram_resp_fifo: synchronous byte FIFO with combinational head
//   clk   : clock
//   rst   : asynchronous reset, active low
//   push  : write wdata (dropped when full unless a pop happens in the same cycle)
//   pop   : remove head (ignored when empty)
//   wdata : byte to write
//   full  : DEPTH entries held
//   empty : no entries held
//   head  : oldest entry, 0 when empty
module ram_resp_fifo #(
    parameter int DEPTH = 8,
    parameter int W     = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         push,
    input  logic         pop,
    input  logic [W-1:0] wdata,
    output logic         full,
    output logic         empty,
    output logic [W-1:0] head
);
    localparam int AW = $clog2(DEPTH);
    logic [W-1:0]  mem [DEPTH];
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic [AW:0]   count;
    logic          do_push, do_pop;

    // A pop frees the slot the simultaneous push needs, so full+push+pop is legal.
    assign do_pop  = pop & ~empty;
    assign do_push = push & (~full | do_pop);
    assign full    = count == (AW+1)'(DEPTH);
    assign empty   = count == '0;
    assign head    = empty ? '0 : mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= wdata;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + AW'(1);
            if (do_pop) rd_ptr <= rd_ptr + AW'(1);
            count <= count + (AW+1)'(do_push) - (AW+1)'(do_pop);
        end
    end
endmodule

// File: rtl/ram_responder.sv
// ram_responder: byte-serial RAM target with TX FIFO, status and cycle counter I/O window
//   clk         : clock
//   rst         : asynchronous reset, active low
//   ram_addr_i  : byte address from the controller
//   ram_rw_i    : 0 read, 1 write
//   ram_wdata_i : write byte
//   ram_rdata_o : registered read byte (one cycle after the address)
//   tx_data_o   : TX FIFO head byte
//   tx_valid_o  : TX FIFO non-empty
//   tx_ready_i  : sink takes the head byte when valid and ready
// Optional: define RAM_RESP_CYCLE_CNT_EN for the cycle counter at offsets 0x8..0xB.
module ram_responder
    import ram_resp_pkg::*;
#(
    parameter int          ADDR_W    = 17,
    parameter logic [31:0] IO_BASE   = 32'h30000,
    parameter int          TXF_DEPTH = 8
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] ram_addr_i,
    input  logic        ram_rw_i,
    input  logic [7:0]  ram_wdata_i,
    output logic [7:0]  ram_rdata_o,
    output logic [7:0]  tx_data_o,
    output logic        tx_valid_o,
    input  logic        tx_ready_i
);
    logic [7:0] mem [2**ADDR_W];
    region_t    region;
    logic [3:0] off;
    logic [7:0] status, io_byte, rd_next;
    logic       push, pop, full, empty, ovf, ovf_clr, io_wr;

    // Offsets fit in 4 bits, so only the low bits of the subtraction matter.
    assign off = ram_addr_i[3:0] - IO_BASE[3:0];
    assign region = ({1'b0, ram_addr_i} < (33'd1 << ADDR_W)) ? REG_RAM :
                    (ram_addr_i >= IO_BASE && ram_addr_i - IO_BASE <= 32'(IO_LAST)) ? REG_IO : REG_NONE;
    assign io_wr   = ram_rw_i && region == REG_IO;
    assign push    = io_wr && off == IO_TX;
    assign ovf_clr = io_wr && off == IO_STAT;
    assign pop     = tx_valid_o & tx_ready_i;
    assign tx_valid_o = ~empty;

    always_comb begin
        status           = '0;
        status[ST_EMPTY] = empty;
        status[ST_FULL]  = full;
        status[ST_OVF]   = ovf;
    end

`ifdef RAM_RESP_CYCLE_CNT_EN
    logic [31:0] cnt, snap;
    logic        snap_ld;

    // Reading byte 0 freezes the whole counter so bytes 1..3 never tear.
    assign snap_ld = !ram_rw_i && region == REG_IO && off == IO_CNT0;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt  <= '0;
            snap <= '0;
        end else begin
            cnt <= cnt + 32'd1;
            if (snap_ld) snap <= cnt;
        end
    end

    assign io_byte = off == IO_CNT0 ? cnt[7:0] :
                     off == IO_CNT1 ? snap[15:8] :
                     off == IO_CNT2 ? snap[23:16] :
                     off == IO_CNT3 ? snap[31:24] :
                     off == IO_STAT ? status : 8'h00;
`else
    assign io_byte = off == IO_STAT ? status : 8'h00;
`endif

    assign rd_next = region == REG_RAM ? mem[ram_addr_i[ADDR_W-1:0]] :
                     region == REG_IO  ? io_byte : 8'h00;

    always_ff @(posedge clk) begin
        if (ram_rw_i && region == REG_RAM) mem[ram_addr_i[ADDR_W-1:0]] <= ram_wdata_i;
    end

    // Writes leave the read register holding its previous byte.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) ram_rdata_o <= '0;
        else if (!ram_rw_i) ram_rdata_o <= rd_next;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) ovf <= 1'b0;
        else if (push && full && !pop) ovf <= 1'b1;
        else if (ovf_clr) ovf <= 1'b0;
    end

    ram_resp_fifo #(.DEPTH(TXF_DEPTH), .W(8)) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (push),
        .pop   (pop),
        .wdata (ram_wdata_i),
        .full  (full),
        .empty (empty),
        .head  (tx_data_o)
    );
endmodule
